// File: rtl/multu_sequencer.sv
// multu_sequencer: multi-cycle shift-add multiplier for the EX stage.
// Owns HI/LO and stalls the pipeline while a multiply is iterating.
// Build option: define MULT_SIGNED_EN to add the is_signed port (MULT support).
module multu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] acc_sum_s;
  logic [2*WIDTH-1:0] result_s;

`ifdef MULT_SIGNED_EN
  logic               sign_r;
  logic               sign_s;

  // Magnitude of a two's-complement operand when signed mode is requested.
  // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    if (sgn && v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Two's-complement negation of the full-width product.
  function automatic logic [2*WIDTH-1:0] neg_of(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction
`endif

  // Operand conditioning, next accumulator value and the value written to HI/LO.
  always_comb begin
    acc_sum_s = acc_r + (mplr_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
`ifdef MULT_SIGNED_EN
    a_mag_s  = mag_of(op_a, is_signed);
    b_mag_s  = mag_of(op_b, is_signed);
    sign_s   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    if (sign_r) begin
      result_s = neg_of(acc_sum_s);
    end else begin
      result_s = acc_sum_s;
    end
`else
    a_mag_s  = op_a;
    b_mag_s  = op_b;
    result_s = acc_sum_s;
`endif
  end

  // Sequencer FSM with datapath registers; HI/LO update only on RUN->DONE or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {(2*WIDTH){1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
`ifdef MULT_SIGNED_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand_r <= {{WIDTH{1'b0}}, a_mag_s};
            mplr_r  <= b_mag_s;
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
`ifdef MULT_SIGNED_EN
            sign_r  <= sign_s;
`endif
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_sum_s;
          mcand_r <= mcand_r << 1;
          mplr_r  <= mplr_r >> 1;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(WIDTH - 1)) begin
            hi_r    <= result_s[2*WIDTH-1:WIDTH];
            lo_r    <= result_s[WIDTH-1:0];
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_r == ST_RUN);
  assign done  = (state_r == ST_DONE);
  assign stall = busy & (start | rd_hi | rd_lo);
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed self-checking bench for multu_sequencer (WIDTH=32).
module tb_multu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_hi;
  logic        rd_lo;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULT_SIGNED_EN
  logic        is_signed;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_cnt  = 0;
  int mark;
  int n;

  multu_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
`ifdef MULT_SIGNED_EN
    .is_signed(is_signed),
`endif
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic sg);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
`ifdef MULT_SIGNED_EN
    is_signed = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0; rd_hi = 1'b0; rd_lo = 1'b0;
`ifdef MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    // 1. reset state
    step(2);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b1;
    step(1);

    // 2. max x max, latency and single done pulse
    mark = done_cnt;
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step(1);
    end
    check_val("t2_busy_cycles", 64'(n), 64'd32);
    check_val("t2_done", {63'd0, done}, 64'd1);
    check_val("t2_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    step(1);
    check_val("t2_done_low", {63'd0, done}, 64'd0);
    check_val("t2_done_pulses", 64'(done_cnt - mark), 64'd1);

    // 3. MFLO stalls during RUN, not in DONE
    do_start(32'd3, 32'd5, 1'b0);
    step(4);
    rd_lo = 1'b1;
    #1;
    check_val("t3_stall_early", {63'd0, stall}, 64'd1);
    step(27);
    check_val("t3_busy_last", {63'd0, busy}, 64'd1);
    check_val("t3_stall_last", {63'd0, stall}, 64'd1);
    step(1);
    check_val("t3_stall_done", {63'd0, stall}, 64'd0);
    check_val("t3_done", {63'd0, done}, 64'd1);
    check_val("t3_hilo", {hi, lo}, 64'd15);
    rd_lo = 1'b0;
    step(1);

    // 4. held MULTU accepted in DONE
    mark = done_cnt;
    do_start(32'd7, 32'd9, 1'b0);
    step(2);
    start = 1'b1; op_a = 32'd2; op_b = 32'h8000_0000;
    #1;
    check_val("t4_stall_held", {63'd0, stall}, 64'd1);
    step(29);
    check_val("t4_stall_last", {63'd0, stall}, 64'd1);
    step(1);
    check_val("t4_done1", {63'd0, done}, 64'd1);
    check_val("t4_stall_done", {63'd0, stall}, 64'd0);
    check_val("t4_hilo1", {hi, lo}, 64'd63);
    step(1);
    start = 1'b0;
    check_val("t4_busy2", {63'd0, busy}, 64'd1);
    step(31);
    check_val("t4_hold_hilo", {hi, lo}, 64'd63);
    step(1);
    check_val("t4_done2", {63'd0, done}, 64'd1);
    check_val("t4_hilo2", {hi, lo}, 64'h0000_0001_0000_0000);
    step(1);
    check_val("t4_done_pulses", 64'(done_cnt - mark), 64'd2);

    // 5. reset aborts an in-flight multiply
    mark = done_cnt;
    do_start(32'h1234_5678, 32'd9, 1'b0);
    step(10);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_val("t5_busy", {63'd0, busy}, 64'd0);
    check_val("t5_hilo", {hi, lo}, 64'd0);
    step(40);
    check_val("t5_no_done", 64'(done_cnt - mark), 64'd0);
    do_start(32'd6, 32'd7, 1'b0);
    step(32);
    check_val("t5_done", {63'd0, done}, 64'd1);
    check_val("t5_hilo2", {hi, lo}, 64'd42);
    step(1);

    // 5b. zero multiplier still takes full latency
    do_start(32'hDEAD_BEEF, 32'd0, 1'b0);
    step(31);
    check_val("t5b_busy", {63'd0, busy}, 64'd1);
    step(1);
    check_val("t5b_hilo", {hi, lo}, 64'd0);
    step(1);

`ifdef MULT_SIGNED_EN
    // 6. signed versus unsigned
    do_start(32'hFFFF_FFFD, 32'd7, 1'b1);
    step(32);
    check_val("t6_signed", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    step(1);
    do_start(32'hFFFF_FFFD, 32'd7, 1'b0);
    step(32);
    check_val("t6_unsigned", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    step(1);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
